// File: rtl/i2s_stereo_tx.sv
// Philips-I2S stereo transmitter: buffers 16-bit L/R pairs in a small FIFO and
// serializes one pair per 64-BCLK frame with internally generated BCLK/LRCLK.
module i2s_stereo_tx #(
    parameter int unsigned BCLK_HALF  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_L,
    input  logic [15:0] in_R,
    input  logic        valid_in,
    output logic        ready,
    input  logic        clear_flags,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun,
    output logic        overflow
);

    localparam int unsigned DivW = $clog2(BCLK_HALF);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
    localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic            bclk_q, bclk_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic [15:0]     left_q, left_d;
    logic [15:0]     right_q, right_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            underrun_q, underrun_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic        div_wrap;
    logic        bclk_fall;
    logic        frame_load;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [4:0]  slot;
    logic [3:0]  bit_idx;
    logic [15:0] word;

    always_comb begin
        div_wrap   = (div_cnt_q == DivLast);
        div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d     = div_wrap ? ~bclk_q : bclk_q;
        bclk_fall  = div_wrap & bclk_q;
        bit_cnt_d  = bclk_fall ? bit_cnt_q + 6'd1 : bit_cnt_q;
        frame_load = bclk_fall & (bit_cnt_q == 6'd63);

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == Depth);
        pop        = frame_load & ~fifo_empty;
        // A same-cycle pop frees the slot the push needs.
        push       = valid_in & (~fifo_full | pop);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        ready_d = (count_d < Depth);

        left_d  = left_q;
        right_d = right_q;
        if (frame_load) begin
            left_d  = pop ? mem_q[rd_ptr_q][31:16] : 16'h0000;
            right_d = pop ? mem_q[rd_ptr_q][15:0]  : 16'h0000;
        end

        // Slot h carries word[16-h] for h = 1..16: one-BCLK delay then MSB first.
        slot    = bit_cnt_d[4:0];
        bit_idx = 4'(5'd16 - slot);
        word    = bit_cnt_d[5] ? right_q : left_q;
        lrclk_d = bclk_fall ? bit_cnt_d[5] : lrclk_q;
        sdata_d = sdata_q;
        if (bclk_fall) begin
            sdata_d = ((slot != 5'd0) && (slot <= 5'd16)) ? word[bit_idx] : 1'b0;
        end

        underrun_d = (clear_flags ? 1'b0 : underrun_q) | (frame_load & fifo_empty);
        overflow_d = (clear_flags ? 1'b0 : overflow_q) | (valid_in & ~push);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= 6'd63;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            left_q     <= 16'h0000;
            right_q    <= 16'h0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            left_q     <= left_d;
            right_q    <= right_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_L, in_R};
        end
    end

    assign ready     = ready_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/i2s_stereo_tx.md
# i2s_stereo_tx

Serializes the 44.1 kHz stereo stream from the output conversion stage into a Philips-I2S bitstream for the external audio DAC. Volume-scaled 16-bit left/right pairs go into a small stereo FIFO. One pair is shifted out per 64-BCLK frame. BCLK and LRCLK are generated internally from the system clock, and FIFO underrun/overflow are reported as sticky flags.

## Interface
- BCLK_HALF, 8: clk cycles per BCLK half-period; 45.1584 MHz clk / 16 = 2.8224 MHz = 64 × 44.1 kHz; legal ≥ 2
- FIFO_DEPTH, 4: stereo-pair entries; power of two, ≥ 2
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_L  in  16  signed left sample
- in_R  in  16  signed right sample
- valid_in  in  1  one-cycle strobe: in_L/in_R form one pair to push
- ready  out  1  registered; 1 when FIFO count < FIFO_DEPTH; advisory only
- clear_flags  in  1  synchronous clear of underrun/overflow
- i2s_bclk  out  1  bit clock, registered
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first, two's complement
- underrun  out  1  sticky: frame started with FIFO empty
- overflow  out  1  sticky: push dropped because FIFO full

## Operation
- Divider counter div_cnt runs 0..BCLK_HALF-1. At the wrap, i2s_bclk toggles.
  - A toggle 0→1 is a BCLK rising edge. The DAC samples on it.
  - A toggle 1→0 is a BCLK falling edge. All serial outputs change only on it.
- Bit counter bit_cnt is 6 bits. It increments, mod 64, on each falling edge.
  - i2s_lrclk <= new bit_cnt[5].
  - Slot h = new bit_cnt[4:0].
  - i2s_sdata <= word[16-h] for h = 1..16, else 0. word is the left shift word when bit_cnt[5]=0 and the right word otherwise.
  - This gives a one-BCLK MSB delay after each LRCLK change, plus 15 zero-pad bits.
- Frame load: on the falling edge where bit_cnt wraps 63→0, pop one FIFO entry into the left and right shift words.
  - If the FIFO is empty, load 0/0 and set underrun. The frame then outputs silence.
- Push: when valid_in=1, the pair is written unless the FIFO holds FIFO_DEPTH entries.
  - A pop in the same cycle frees a slot, so the push is accepted.
  - A refused push is discarded, sets overflow, and leaves the FIFO unchanged.
- Push and pop on an empty FIFO in the same cycle: the pop sees empty, so underrun is set and zeros are loaded. The pushed pair is stored for the next frame.
- Sample values pass bit-exact; there is no arithmetic or rounding. 0x8000 is serialized as 1 followed by fifteen 0s.
- underrun and overflow hold until clear_flags=1 or reset.
  - If clear_flags coincides with a new event, the set wins.
- FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is 0..FIFO_DEPTH.

## Timing
- Reset values:
  - i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0
  - div_cnt=0, bit_cnt=63
  - FIFO empty, ready=1, underrun=0, overflow=0
- After reset release, the first rising edge of i2s_bclk is BCLK_HALF clk cycles later. The first falling edge is 2·BCLK_HALF cycles later; it wraps bit_cnt to 0 and performs the first frame load.
- Reset asserted mid-frame immediately forces all reset values. The partial frame and FIFO contents are discarded, with no flags.
- Frame period is 128·BCLK_HALF clk cycles. The left MSB appears on i2s_sdata at the falling edge after the load, 2·BCLK_HALF clk cycles after the load.
- Push latency: a push into an empty FIFO appears in the next frame load, i.e. up to one frame plus 2·BCLK_HALF cycles later.
- ready updates one cycle after the push/pop that changes the count.

## Test plan
- Reset then idle; no pushes.
  - i2s_bclk period = 16 clk cycles.
  - i2s_lrclk toggles every 32 BCLKs, low first after the first load.
  - i2s_sdata stays 0; underrun=1 after the first frame.
- Push one pair L=0x1234, R=0xF00F, then one frame.
  - Left slot bits 1..16 = 0001001000110100.
  - Right slot bits 1..16 = 1111000000001111.
  - Slot bit 0 and bits 17..31 = 0.
  - MSB changes only on falling edges.
- Push 5 pairs back-to-back with FIFO_DEPTH=4 before any load.
  - First 4 stored; the 5th is dropped and overflow=1.
  - ready=0 from the cycle after the 4th push.
  - Subsequent frames replay pairs 1–4 in order.
- Full FIFO, push timed on the load cycle.
  - Push accepted, overflow stays 0, count stays 4.
- Empty FIFO, push timed on the load cycle with 0x7FFF/0x8000.
  - That frame outputs zeros and underrun=1.
  - The next frame outputs 0x7FFF/0x8000.
- Assert reset_n low for 1 cycle during the right slot of a frame.
  - Outputs go to reset values asynchronously and flags clear.
  - The timing restarts exactly as after power-up reset.
